// File: rtl/max6675_model_if.sv
// Serial link between the thermocouple reader (master) and the converter model (slave).
interface max6675_model_if;
   logic cs;
   logic clkS;
   logic so;

   modport master (output cs, output clkS, input so);
   modport slave  (input cs, input clkS, output so);
endinterface

// File: rtl/max6675_model.sv
// MAX6675-style converter model: periodic temperature capture, 16-bit word shifted out on so.
module max6675_model #(
   parameter int unsigned CONV_CYCLES = 11_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   max6675_model_if.slave        spi,
   input  logic [11:0]           tempIn,
   input  logic                  openTc,
   output logic                  converting,
   output logic                  frameDone,
   output logic [11:0]           sampled
);

   localparam int unsigned   CW       = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CONV_CYCLES - 1);

   typedef enum logic [1:0] {CONV, READY, SHIFT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [11:0]   temp_q, temp_d;
   logic          open_q, open_d;
   logic [15:0]   shreg_q, shreg_d;
   logic [4:0]    bitcnt_q, bitcnt_d;
   logic          fd_q, fd_d;

   logic cs_meta_q, cs_sync_q, cs_dly_q;
   logic ck_meta_q, ck_sync_q, ck_dly_q;
   logic cs_fall, cs_rise, ck_fall;
   logic [15:0] word;

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_meta_q <= 1'b1;
         cs_sync_q <= 1'b1;
         cs_dly_q  <= 1'b1;
         ck_meta_q <= 1'b0;
         ck_sync_q <= 1'b0;
         ck_dly_q  <= 1'b0;
      end else begin
         cs_meta_q <= spi.cs;
         cs_sync_q <= cs_meta_q;
         cs_dly_q  <= cs_sync_q;
         ck_meta_q <= spi.clkS;
         ck_sync_q <= ck_meta_q;
         ck_dly_q  <= ck_sync_q;
      end
   end

   assign cs_fall = ~cs_sync_q &  cs_dly_q;
   assign cs_rise =  cs_sync_q & ~cs_dly_q;
   assign ck_fall = ~ck_sync_q &  ck_dly_q;
   assign word    = {1'b0, temp_q, open_q, 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= CONV;
         cnt_q    <= '0;
         temp_q   <= '0;
         open_q   <= 1'b0;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         fd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         temp_q   <= temp_d;
         open_q   <= open_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         fd_q     <= fd_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      temp_d   = temp_q;
      open_d   = open_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      fd_d     = 1'b0;
      unique case (state_q)
         CONV, READY: begin
            // A cs fall aborts any conversion; the previous result is sent.
            if (cs_fall) begin
               shreg_d  = word;
               bitcnt_d = '0;
               state_d  = SHIFT;
            end else if (state_q == CONV) begin
               if (cnt_q == CNT_LAST) begin
                  temp_d  = tempIn;
                  open_d  = openTc;
                  state_d = READY;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         SHIFT: begin
            // cs edge has priority over a coincident clkS fall.
            if (cs_rise) begin
               fd_d    = (bitcnt_q == 5'd16);
               cnt_d   = '0;
               state_d = CONV;
            end else if (ck_fall) begin
               shreg_d = {shreg_q[14:0], 1'b0};
               if (bitcnt_q != 5'd16) bitcnt_d = bitcnt_q + 5'd1;
            end
         end
         default: state_d = CONV;
      endcase
   end

   assign spi.so     = (state_q == SHIFT) & shreg_q[15];
   assign converting = (state_q == CONV);
   assign frameDone  = fd_q;
   assign sampled    = temp_q;

endmodule
